tlb_flush_sequencer: RTL and testbench
======================================

Name: tlb_flush_sequencer

Overview:
- Sits directly downstream of the SATP write guard and consumes its one-cycle `tlb_global_flush` pulse.
- Also accepts SFENCE.VMA requests from the execute stage.
- Stalls the MMU, waits for in-flight translations to drain, then walks every I-TLB and D-TLB index, issuing one invalidate per cycle (global or ASID-filtered).
- Signals completion so the pipeline can refetch under the new address space.

Parameters:
- ENTRIES, 16, TLB entries per TLB (I and D identical); power of two, ≥2.
- ASID_W, 6, ASID width, matching the SATP ASID field.
- DRAIN_MAX, 15, max cycles to wait for `mmu_idle` before forcing the sweep.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tlb_global_flush  in  1  one-cycle pulse from the SATP guard: flush all entries
- sfence_valid  in  1  SFENCE.VMA request valid
- sfence_ready  out  1  request accepted when valid&&ready
- sfence_asid_en  in  1  1 = flush only entries with matching ASID (rs2≠x0)
- sfence_asid  in  ASID_W  ASID filter
- mmu_idle  in  1  no translation outstanding in I/D MMU
- mmu_stall  out  1  block new translations
- tlb_inv_en  out  1  invalidate strobe to both TLBs
- tlb_inv_idx  out  $clog2(ENTRIES)  entry index being invalidated
- tlb_inv_asid_en  out  1  TLB clears entry only if its ASID matches and it is non-global
- tlb_inv_asid  out  ASID_W  ASID for the filtered invalidate
- flush_done  out  1  one-cycle pulse when the sweep completes
- busy  out  1  sequencer not IDLE

Behaviour:
- Clocking/reset:
  - All state updates on posedge clk.
  - rst_n=0 sampled at an edge forces state IDLE and clears all registers.
  - Reset values: mmu_stall=0, tlb_inv_en=0, tlb_inv_idx=0, tlb_inv_asid_en=0, tlb_inv_asid=0, flush_done=0, busy=0, sfence_ready=1.
  - Reset mid-sweep abandons the sweep with no done pulse.
- States: IDLE, DRAIN, SWEEP, DONE.
- IDLE:
  - sfence_ready=1.
  - On `tlb_global_flush` or `sfence_valid`: latch request, go to DRAIN next cycle.
  - Latched request: asid_en = sfence_valid && sfence_asid_en && !tlb_global_flush, with sfence_asid.
  - Simultaneous global + sfence: both are consumed (handshake completes), global wins, asid_en=0.
- DRAIN:
  - mmu_stall=1, busy=1, sfence_ready=0. Drain counter starts at 0.
  - Go to SWEEP on the cycle after mmu_idle=1, or when the counter reaches DRAIN_MAX (forced).
  - Counter saturates at DRAIN_MAX.
- SWEEP:
  - mmu_stall=1, busy=1, tlb_inv_en=1.
  - tlb_inv_idx starts at 0 and increments by 1 each cycle.
  - tlb_inv_asid_en and tlb_inv_asid are driven from the latched request.
  - After the cycle with idx=ENTRIES-1, go to DONE; idx wraps to 0.
  - A sweep always takes exactly ENTRIES cycles.
- DONE:
  - flush_done=1 for exactly one cycle, mmu_stall=1, tlb_inv_en=0.
  - Next state IDLE; mmu_stall drops in IDLE.
- Pending requests:
  - `tlb_global_flush` arriving in DRAIN/SWEEP/DONE sets pending_global.
  - In DRAIN or SWEEP it also upgrades the active request in place (asid_en=0).
  - The upgrade in SWEEP restarts idx at 0 on the next cycle so no entry escapes the global invalidate.
  - If the pulse arrives in DONE, pending_global stays set.
  - Leaving DONE with pending_global=1 goes straight to DRAIN instead of IDLE: new flush_done later, mmu_stall stays 1 throughout.
  - pending_global clears when consumed.
- sfence_valid while busy: held off by sfence_ready=0. The requester must hold valid and its payload stable.
- Latency, global flush from IDLE with mmu_idle=1:
  - pulse at cycle T → DRAIN at T+1 → SWEEP T+2 … T+ENTRIES+1 → flush_done at T+ENTRIES+2.
- Outputs are registered; no combinational path from inputs to tlb_inv_* or flush_done.

Test Plan:
- Global pulse in IDLE, mmu_idle=1, ENTRIES=16 → tlb_inv_en high for 16 consecutive cycles, idx 0..15, asid_en=0; flush_done exactly 18 cycles after the pulse; mmu_stall high from T+1 through T+18.
- SFENCE with asid_en=1, asid=6'h33, mmu_idle held 0 for 5 cycles → sfence_ready drops after handshake; 5-cycle drain then sweep with tlb_inv_asid_en=1, tlb_inv_asid=6'h33; one flush_done.
- mmu_idle stuck 0 → forced sweep after DRAIN_MAX=15 cycles; sweep and done proceed normally.
- ASID sweep at idx=7 when a global pulse arrives → idx restarts at 0 with asid_en=0; 16 global invalidates follow; single flush_done.
- Global pulse during DONE → second DRAIN/SWEEP follows immediately, mmu_stall never drops; two flush_done pulses total.
- rst_n=0 at SWEEP idx=4 → next cycle all outputs at reset values, state IDLE, no flush_done; a new global pulse then runs a full 16-entry sweep.

Source files
------------

// File: rtl/tlb_flush_sequencer.sv
// TLB flush sequencer: stalls the MMU, waits for outstanding translations to
// drain, then walks every I/D-TLB index issuing one invalidate per cycle.
// Global flushes from the SATP guard take precedence over ASID-filtered
// SFENCE.VMA requests. All outputs come straight from flops.
module tlb_flush_sequencer #(
    parameter int ENTRIES   = 16,
    parameter int ASID_W    = 6,
    parameter int DRAIN_MAX = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tlb_global_flush,
    input  logic                        sfence_valid,
    output logic                        sfence_ready,
    input  logic                        sfence_asid_en,
    input  logic [ASID_W-1:0]           sfence_asid,
    input  logic                        mmu_idle,
    output logic                        mmu_stall,
    output logic                        tlb_inv_en,
    output logic [$clog2(ENTRIES)-1:0]  tlb_inv_idx,
    output logic                        tlb_inv_asid_en,
    output logic [ASID_W-1:0]           tlb_inv_asid,
    output logic                        flush_done,
    output logic                        busy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_asid_en_q, req_asid_en_d;
    logic [ASID_W-1:0]   req_asid_q, req_asid_d;
    logic                pending_q, pending_d;

    logic                sfence_ready_q, mmu_stall_q, tlb_inv_en_q;
    logic                tlb_inv_asid_en_q, flush_done_q, busy_q;
    logic [ASID_W-1:0]   tlb_inv_asid_q;

    // Next-state logic: request latching, drain timeout, index walk, upgrades
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        req_asid_en_d = req_asid_en_q;
        req_asid_d    = req_asid_q;
        pending_d     = pending_q;
        case (state_q)
            IDLE: begin
                if (tlb_global_flush || sfence_valid) begin
                    state_d       = DRAIN;
                    cnt_d         = '0;
                    idx_d         = '0;
                    // A simultaneous global pulse swallows the SFENCE and wins.
                    req_asid_en_d = sfence_valid && sfence_asid_en && !tlb_global_flush;
                    req_asid_d    = req_asid_en_d ? sfence_asid : '0;
                end
            end
            DRAIN: begin
                if (tlb_global_flush) begin
                    req_asid_en_d = 1'b0;
                    req_asid_d    = '0;
                end
                if (mmu_idle || cnt_q == CNT_W'(DRAIN_MAX)) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SWEEP: begin
                if (tlb_global_flush) begin
                    // Restart so entries already passed get the global invalidate too.
                    req_asid_en_d = 1'b0;
                    req_asid_d    = '0;
                    idx_d         = '0;
                end else if (idx_q == IDX_W'(ENTRIES - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                pending_d = pending_q || tlb_global_flush;
                if (pending_d) begin
                    state_d       = DRAIN;
                    cnt_d         = '0;
                    idx_d         = '0;
                    req_asid_en_d = 1'b0;
                    req_asid_d    = '0;
                    pending_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            req_asid_en_q <= 1'b0;
            req_asid_q    <= '0;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            req_asid_en_q <= req_asid_en_d;
            req_asid_q    <= req_asid_d;
            pending_q     <= pending_d;
        end
    end

    // Output flops decoded from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sfence_ready_q    <= 1'b1;
            mmu_stall_q       <= 1'b0;
            tlb_inv_en_q      <= 1'b0;
            tlb_inv_asid_en_q <= 1'b0;
            tlb_inv_asid_q    <= '0;
            flush_done_q      <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            sfence_ready_q    <= (state_d == IDLE);
            mmu_stall_q       <= (state_d != IDLE);
            busy_q            <= (state_d != IDLE);
            tlb_inv_en_q      <= (state_d == SWEEP);
            flush_done_q      <= (state_d == DONE);
            tlb_inv_asid_en_q <= (state_d == SWEEP) && req_asid_en_d;
            tlb_inv_asid_q    <= ((state_d == SWEEP) && req_asid_en_d) ? req_asid_d : '0;
        end
    end

    assign sfence_ready    = sfence_ready_q;
    assign mmu_stall       = mmu_stall_q;
    assign tlb_inv_en      = tlb_inv_en_q;
    assign tlb_inv_idx     = idx_q;
    assign tlb_inv_asid_en = tlb_inv_asid_en_q;
    assign tlb_inv_asid    = tlb_inv_asid_q;
    assign flush_done      = flush_done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_tlb_flush_sequencer.sv
// Directed testbench for tlb_flush_sequencer.
module tb_tlb_flush_sequencer;

    localparam int ENTRIES   = 16;
    localparam int ASID_W    = 6;
    localparam int DRAIN_MAX = 15;

    // Status vector order: {mmu_stall, busy, tlb_inv_en, flush_done, sfence_ready}
    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_DRAIN = 5'b11000;
    localparam logic [4:0] S_SWEEP = 5'b11100;
    localparam logic [4:0] S_DONE  = 5'b11010;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tlb_global_flush;
    logic              sfence_valid;
    logic              sfence_ready;
    logic              sfence_asid_en;
    logic [ASID_W-1:0] sfence_asid;
    logic              mmu_idle;
    logic              mmu_stall;
    logic              tlb_inv_en;
    logic [3:0]        tlb_inv_idx;
    logic              tlb_inv_asid_en;
    logic [ASID_W-1:0] tlb_inv_asid;
    logic              flush_done;
    logic              busy;
    logic [4:0]        st;

    int checks   = 0;
    int failures = 0;

    assign st = {mmu_stall, busy, tlb_inv_en, flush_done, sfence_ready};

    always #5 clk = ~clk;

    tlb_flush_sequencer #(.ENTRIES(ENTRIES), .ASID_W(ASID_W), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .tlb_global_flush(tlb_global_flush),
        .sfence_valid(sfence_valid), .sfence_ready(sfence_ready),
        .sfence_asid_en(sfence_asid_en), .sfence_asid(sfence_asid),
        .mmu_idle(mmu_idle), .mmu_stall(mmu_stall), .tlb_inv_en(tlb_inv_en),
        .tlb_inv_idx(tlb_inv_idx), .tlb_inv_asid_en(tlb_inv_asid_en),
        .tlb_inv_asid(tlb_inv_asid), .flush_done(flush_done), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tlb_global_flush = 1'b0; sfence_valid = 1'b0;
        sfence_asid_en = 1'b0; sfence_asid = '0; mmu_idle = 1'b1;
        step(); step();
        checks++;
        if ({st, tlb_inv_idx, tlb_inv_asid_en, tlb_inv_asid} !== {S_IDLE, 4'd0, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL reset_outputs got st=%b idx=%0d aen=%b asid=%h want st=%b idx=0 aen=0 asid=0",
                     st, tlb_inv_idx, tlb_inv_asid_en, tlb_inv_asid, S_IDLE);
        end
        rst_n = 1'b1;
        step();
        $display("reset: st=%b", st);
    endtask

    task automatic test_global();
        mmu_idle = 1'b1; tlb_global_flush = 1'b1;
        step();
        tlb_global_flush = 1'b0;
        checks++;
        if (st !== S_DRAIN) begin
            failures++; $display("FAIL global_drain got st=%b want %b", st, S_DRAIN);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            step();
            checks++;
            if ({st, tlb_inv_idx, tlb_inv_asid_en} !== {S_SWEEP, 4'(i), 1'b0}) begin
                failures++;
                $display("FAIL global_sweep%0d got st=%b idx=%0d aen=%b want st=%b idx=%0d aen=0",
                         i, st, tlb_inv_idx, tlb_inv_asid_en, S_SWEEP, i);
            end
        end
        step();
        checks++;
        if (st !== S_DONE) begin
            failures++; $display("FAIL global_done got st=%b want %b", st, S_DONE);
        end
        step();
        checks++;
        if (st !== S_IDLE) begin
            failures++; $display("FAIL global_idle got st=%b want %b", st, S_IDLE);
        end
        $display("global flush: sweep of %0d entries, done at T+18", ENTRIES);
    endtask

    task automatic test_sfence_asid();
        mmu_idle = 1'b0; sfence_valid = 1'b1; sfence_asid_en = 1'b1; sfence_asid = 6'h33;
        step();
        sfence_valid = 1'b0; sfence_asid_en = 1'b0; sfence_asid = '0;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (st !== S_DRAIN) begin
                failures++; $display("FAIL sfence_drain%0d got st=%b want %b", k, st, S_DRAIN);
            end
            mmu_idle = (k == 5);
            step();
        end
        for (int i = 0; i < ENTRIES; i++) begin
            checks++;
            if ({st, tlb_inv_idx, tlb_inv_asid_en, tlb_inv_asid} !== {S_SWEEP, 4'(i), 1'b1, 6'h33}) begin
                failures++;
                $display("FAIL sfence_sweep%0d got st=%b idx=%0d aen=%b asid=%h want st=%b idx=%0d aen=1 asid=33",
                         i, st, tlb_inv_idx, tlb_inv_asid_en, tlb_inv_asid, S_SWEEP, i);
            end
            step();
        end
        checks++;
        if ({st, tlb_inv_asid_en} !== {S_DONE, 1'b0}) begin
            failures++; $display("FAIL sfence_done got st=%b aen=%b want %b aen=0", st, tlb_inv_asid_en, S_DONE);
        end
        step();
        checks++;
        if (st !== S_IDLE) begin
            failures++; $display("FAIL sfence_idle got st=%b want %b", st, S_IDLE);
        end
        $display("sfence asid=33: 5-cycle drain then filtered sweep");
    endtask

    task automatic test_forced_drain();
        int n;
        mmu_idle = 1'b0; tlb_global_flush = 1'b1;
        step();
        tlb_global_flush = 1'b0;
        n = 0;
        while (!tlb_inv_en && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n !== DRAIN_MAX + 1) begin
            failures++; $display("FAIL forced_drain_len got %0d cycles want %0d", n, DRAIN_MAX + 1);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            checks++;
            if ({st, tlb_inv_idx} !== {S_SWEEP, 4'(i)}) begin
                failures++;
                $display("FAIL forced_sweep%0d got st=%b idx=%0d want st=%b idx=%0d", i, st, tlb_inv_idx, S_SWEEP, i);
            end
            step();
        end
        checks++;
        if (st !== S_DONE) begin
            failures++; $display("FAIL forced_done got st=%b want %b", st, S_DONE);
        end
        mmu_idle = 1'b1;
        step();
        $display("forced drain: %0d drain cycles", n);
    endtask

    task automatic test_upgrade();
        mmu_idle = 1'b1; sfence_valid = 1'b1; sfence_asid_en = 1'b1; sfence_asid = 6'h33;
        step();
        sfence_valid = 1'b0; sfence_asid_en = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({st, tlb_inv_idx, tlb_inv_asid_en} !== {S_SWEEP, 4'(i), 1'b1}) begin
                failures++;
                $display("FAIL upgrade_pre%0d got st=%b idx=%0d aen=%b want st=%b idx=%0d aen=1",
                         i, st, tlb_inv_idx, tlb_inv_asid_en, S_SWEEP, i);
            end
            tlb_global_flush = (i == 7);
            step();
        end
        tlb_global_flush = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            checks++;
            if ({st, tlb_inv_idx, tlb_inv_asid_en, tlb_inv_asid} !== {S_SWEEP, 4'(i), 1'b0, 6'd0}) begin
                failures++;
                $display("FAIL upgrade_post%0d got st=%b idx=%0d aen=%b asid=%h want st=%b idx=%0d aen=0 asid=0",
                         i, st, tlb_inv_idx, tlb_inv_asid_en, tlb_inv_asid, S_SWEEP, i);
            end
            step();
        end
        checks++;
        if (st !== S_DONE) begin
            failures++; $display("FAIL upgrade_done got st=%b want %b", st, S_DONE);
        end
        step();
        checks++;
        if (st !== S_IDLE) begin
            failures++; $display("FAIL upgrade_single_done got st=%b want %b", st, S_IDLE);
        end
        $display("upgrade at idx 7: restarted global sweep");
    endtask

    task automatic test_back_to_back();
        mmu_idle = 1'b1; tlb_global_flush = 1'b1;
        step();
        tlb_global_flush = 1'b0;
        for (int i = 0; i <= ENTRIES; i++) step();
        checks++;
        if (st !== S_DONE) begin
            failures++; $display("FAIL b2b_done1 got st=%b want %b", st, S_DONE);
        end
        tlb_global_flush = 1'b1;
        step();
        tlb_global_flush = 1'b0;
        checks++;
        if (st !== S_DRAIN) begin
            failures++; $display("FAIL b2b_redrain got st=%b want %b", st, S_DRAIN);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            step();
            checks++;
            if ({st, tlb_inv_idx} !== {S_SWEEP, 4'(i)}) begin
                failures++;
                $display("FAIL b2b_sweep%0d got st=%b idx=%0d want st=%b idx=%0d", i, st, tlb_inv_idx, S_SWEEP, i);
            end
        end
        step();
        checks++;
        if (st !== S_DONE) begin
            failures++; $display("FAIL b2b_done2 got st=%b want %b", st, S_DONE);
        end
        step();
        checks++;
        if (st !== S_IDLE) begin
            failures++; $display("FAIL b2b_idle got st=%b want %b", st, S_IDLE);
        end
        $display("back-to-back: pulse in DONE chained a second sweep");
    endtask

    task automatic test_reset_mid_sweep();
        mmu_idle = 1'b1; tlb_global_flush = 1'b1;
        step();
        tlb_global_flush = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({st, tlb_inv_idx} !== {S_SWEEP, 4'd4}) begin
            failures++; $display("FAIL midrst_pre got st=%b idx=%0d want st=%b idx=4", st, tlb_inv_idx, S_SWEEP);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({st, tlb_inv_idx, tlb_inv_asid_en, tlb_inv_asid} !== {S_IDLE, 4'd0, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL midrst_outputs got st=%b idx=%0d aen=%b asid=%h want st=%b idx=0",
                     st, tlb_inv_idx, tlb_inv_asid_en, tlb_inv_asid, S_IDLE);
        end
        step();
        checks++;
        if (st !== S_IDLE) begin
            failures++; $display("FAIL midrst_stay_idle got st=%b want %b", st, S_IDLE);
        end
        tlb_global_flush = 1'b1;
        step();
        tlb_global_flush = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            step();
            checks++;
            if ({st, tlb_inv_idx} !== {S_SWEEP, 4'(i)}) begin
                failures++;
                $display("FAIL midrst_sweep%0d got st=%b idx=%0d want st=%b idx=%0d", i, st, tlb_inv_idx, S_SWEEP, i);
            end
        end
        step();
        checks++;
        if (st !== S_DONE) begin
            failures++; $display("FAIL midrst_done got st=%b want %b", st, S_DONE);
        end
        step();
        $display("reset mid-sweep: abandoned, then full sweep");
    endtask

    initial begin
        test_reset();
        test_global();
        test_sfence_asid();
        test_forced_drain();
        test_upgrade();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
